// File: rtl/salva_bebe_monitor.sv
// Child-in-vehicle safety monitor.
// Debounces the presence and door inputs and applies temperature hysteresis.
// A timed warning escalates to a latched alarm that needs an acknowledge to clear.
// An N-digit multiplexed 7-segment display shows the temperature and the state code.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | system disabled or no child detected
// MONITOR | child present, cabin temperature fine
// VENT    | child present, cabin warm: fan on
// AVISO   | cabin hot: internal warning, escalation timer running
// ALARMA  | external alarm latched until door open + acknowledge
module salva_bebe_monitor #(
    parameter int TEMP_W     = 5,
    parameter int N_DIG      = 4,
    parameter int T_VENT     = 25,
    parameter int T_ALARM    = 30,
    parameter int HYST       = 2,
    parameter int DEB_LEN    = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int WARN_TICKS = 10,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [TEMP_W-1:0] temp,
    input  logic              presencia,
    input  logic              puerta,
    input  logic              ack,
    output logic [N_DIG-1:0]  anodos,
    output logic [6:0]        seg,
    output logic              vent,
    output logic              aaviso,
    output logic              alarma,
    output logic [2:0]        estado
);

    localparam int DW    = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW    = $clog2(WARN_TICKS + 1);
    localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW    = $clog2(N_DIG);
    localparam int N_BCD = N_DIG - 1;
    localparam int BW    = 4 * N_BCD;

    localparam logic [TEMP_W-1:0] TV  = TEMP_W'(T_VENT);
    localparam logic [TEMP_W-1:0] TA  = TEMP_W'(T_ALARM);
    localparam logic [TEMP_W-1:0] TVH = TEMP_W'(T_VENT - HYST);
    localparam logic [TEMP_W-1:0] TAH = TEMP_W'(T_ALARM - HYST);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MONITOR = 3'd1,
        VENT    = 3'd2,
        AVISO   = 3'd3,
        ALARMA  = 3'd4
    } state_t;

    state_t            state, nxt;
    logic [TEMP_W-1:0] temp_q;
    logic [1:0]        raw, filt;
    logic [DW-1:0]     deb_cnt [2];
    logic              pres_f, puerta_f;
    logic [PW-1:0]     presc;
    logic [EW-1:0]     esc_cnt;
    logic              tick, esc_done, aviso_entry;

    logic [SW-1:0]     slot_cnt;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     bcd;
    logic [N_BCD-1:0]  blank;
    logic              nz;
    logic [3:0]        dig_val;
    logic              dig_blank;
    logic [6:0]        seg_nxt;

    assign raw      = {puerta, presencia};
    assign pres_f   = filt[0];
    assign puerta_f = filt[1];

    // Register the cabin temperature once per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) temp_q <= '0;
        else        temp_q <= temp;
    end

    // Debounce: accept a new level only after DEB_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_LEN - 1)) begin
                    filt[i]    <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // The escalation fires on the tick that would bring the count to WARN_TICKS,
    // so ALARMA is entered exactly WARN_TICKS*TICK_DIV clocks after AVISO entry.
    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign esc_done    = tick && (esc_cnt >= EW'(WARN_TICKS - 1));
    assign aviso_entry = (nxt == AVISO) && (state != AVISO);

    // Next-state selection; en dominates, then first-listed condition per state.
    always_comb begin
        nxt = state;
        if (!en) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (pres_f) nxt = MONITOR;
                MONITOR: begin
                    if (!pres_f)           nxt = IDLE;
                    else if (temp_q >= TA) nxt = AVISO;
                    else if (temp_q >= TV) nxt = VENT;
                end
                VENT: begin
                    if (!pres_f)           nxt = IDLE;
                    else if (temp_q >= TA) nxt = AVISO;
                    else if (temp_q < TVH) nxt = MONITOR;
                end
                AVISO: begin
                    if (puerta_f)          nxt = MONITOR;
                    else if (temp_q < TAH) nxt = VENT;
                    else if (esc_done)     nxt = ALARMA;
                end
                ALARMA:  if (ack && puerta_f) nxt = MONITOR;
                default: nxt = IDLE;
            endcase
        end
    end

    // State, escalation timing and registered output decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            esc_cnt <= '0;
            vent    <= 1'b0;
            aaviso  <= 1'b0;
            alarma  <= 1'b0;
            estado  <= 3'd0;
        end else begin
            state <= nxt;
            if (aviso_entry) begin
                presc   <= '0;
                esc_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (state == AVISO && tick) esc_cnt <= esc_cnt + EW'(1);
            end
            vent   <= (nxt == VENT) || (nxt == AVISO) || (nxt == ALARMA);
            aaviso <= (nxt == AVISO) || (nxt == ALARMA);
            alarma <= (nxt == ALARMA);
            estado <= nxt;
        end
    end

    // Double-dabble binary to BCD of temp_q, combinational so digits are never stale.
    always_comb begin
        bcd = '0;
        for (int i = TEMP_W - 1; i >= 0; i--) begin
            for (int d = 0; d < N_BCD; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[BW-2:0], temp_q[i]};
        end
    end

    // Leading-zero blanking; the units digit is always shown.
    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int d = N_BCD - 1; d >= 1; d--) begin
            nz       = nz | (bcd[4*d +: 4] != 4'd0);
            blank[d] = ~nz;
        end
    end

    // Select the digit for the active slot; the top digit shows the state code.
    always_comb begin
        dig_val   = {1'b0, estado};
        dig_blank = 1'b0;
        for (int d = 0; d < N_BCD; d++) begin
            if (idx == IW'(d)) begin
                dig_val   = bcd[4*d +: 4];
                dig_blank = blank[d];
            end
        end
        seg_nxt = dig_blank ? 7'h7F : seg7(dig_val);
    end

    // Slot timer and digit scan; anodos/seg registered together so they stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            anodos   <= '1;
            seg      <= 7'h7F;
        end else begin
            if (slot_cnt == SW'(SCAN_DIV - 1)) begin
                slot_cnt <= '0;
                idx      <= (idx == IW'(N_DIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
            anodos <= ~(N_DIG'(1) << idx);
            seg    <= seg_nxt;
        end
    end

    // Active-low {g,f,e,d,c,b,a} patterns for 0-9; anything else is blank.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

endmodule
